rx_byte_buffer: RTL

- Sits directly downstream of the UART receive stage; the receive stage and this block share the 300 baud clk_in.
- Consumes each validated byte (receive flag + 8-bit parallel data) and acknowledges it with a one-cycle rx_done pulse.
- Queues bytes in a FIFO presented first-word-fall-through to the CPU side.
- Flags overrun when the CPU falls behind, so the receiver never stalls.

---
 rtl/rx_byte_buffer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rx_byte_buffer.sv
// rx_byte_buffer: takes bytes from the UART receive stage and acknowledges
// each one with a one-cycle rx_done pulse. The bytes go into a
// first-word-fall-through FIFO that the CPU side reads.
// A sticky overrun flag records any byte dropped because the FIFO was full,
// so the receiver never has to stall.
// Optional feature macro: RX_BUF_IRQ_EN. It adds a registered irq output that
// is high when the fill level is at or above IRQ_LEVEL, or when overrun is set.
module rx_byte_buffer #(
    parameter int DEPTH     = 8,
    parameter int AW        = $clog2(DEPTH),
    parameter int IRQ_LEVEL = 4
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          receive,
    input  logic [7:0]    rx_data,
    output logic          rx_done,
    output logic [7:0]    cpu_data,
    output logic          cpu_valid,
    input  logic          cpu_read,
    output logic [AW:0]   count,
    output logic          overrun,
    input  logic          overrun_clr
`ifdef RX_BUF_IRQ_EN
    ,
    output logic          irq
`endif
);

    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

    // Parameter legality is checked at elaboration.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("rx_byte_buffer: DEPTH must be a power of two >= 2");
        end
        if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_level
            $error("rx_byte_buffer: IRQ_LEVEL must be in 1..DEPTH");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overrun_q, overrun_d;
    logic            rx_done_q;
    logic [7:0]      mem_q [DEPTH];

    logic            capture;   // IDLE sees a byte this cycle
    logic            pop;
    logic            push;
    logic            drop;

    // Handshake FSM. After an ack, it waits for receive to fall so that
    // one held byte is never captured twice.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (receive) state_d = ACK;
            ACK:      state_d = WAIT_LOW;
            WAIT_LOW: if (!receive) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FIFO datapath. A pop in the same cycle frees a slot, so a push at full
    // is still accepted. A pop when empty does nothing.
    always_comb begin
        capture   = (state_q == IDLE) && receive;
        pop       = cpu_read && (count_q != '0);
        push      = capture && ((count_q < DEPTH_C) || pop);
        drop      = capture && !push;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        count_d   = count_q;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
        // A new overrun takes priority over a clear in the same cycle.
        overrun_d = drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
    end

    // Control and status registers. The FIFO storage is kept out of reset.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            rx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            rx_done_q <= capture;
        end
    end

    // Byte storage write port.
    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

`ifdef RX_BUF_IRQ_EN
    localparam logic [AW:0] LEVEL_C = (AW+1)'(IRQ_LEVEL);
    logic irq_q;

    // The interrupt is registered from the next-state fill level and overrun.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= (count_d >= LEVEL_C) || overrun_d;
    end

    assign irq = irq_q;
`endif

    assign rx_done   = rx_done_q;
    assign cpu_data  = mem_q[rd_ptr_q];
    assign cpu_valid = (count_q != '0);
    assign count     = count_q;
    assign overrun   = overrun_q;

endmodule
